order_say_source: RTL and testbench

//   Initiator for the request$say method interface: issues a programmed sequence of say calls.

---
 rtl/order_say_source.sv | 186 ++++++++++++++++++
 tb/tb_order_say_source.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_say_source.sv
// order_say_source
//   Initiator for the request_say method interface. A run is programmed with
//   base/step/count through the start method, then count say calls are issued
//   with va = base + i*step (modulo 2^WIDTH), honouring the responder's
//   request_say__RDY backpressure. After each accepted call, GAP idle cycles
//   follow. When the run ends, the done method reports how many calls were
//   accepted and how many ISSUE cycles stalled on backpressure.
//
// Ports
//   CLK, nRST          clock (posedge) and asynchronous active-low reset
//   start__ENA/RDY     start method; start_base, start_step, start_count payload
//   abort__ENA/RDY     end the current run early
//   request_say__ENA   say call, request_say_va payload, request_say__RDY input
//   done__ENA/RDY      run report; done_issued, done_stalls payload
//   dbg_state_o        current FSM state (IDLE=0, ISSUE=1, GAPW=2, DONE=3)
//
// Handshake semantics: every method transfers in the cycle where its __ENA is
// high. The initiator side raises __ENA only while the matching __RDY is high,
// and nothing is held or retried. For request_say, ENA is computed from RDY in
// the same cycle, so a call is issued exactly when the responder can take it.
module order_say_source #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int GAP   = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start__ENA,
  input  logic [WIDTH-1:0] start_base,
  input  logic [WIDTH-1:0] start_step,
  input  logic [CNT_W-1:0] start_count,
  output logic             start__RDY,
  input  logic             abort__ENA,
  output logic             abort__RDY,
  output logic             request_say__ENA,
  output logic [WIDTH-1:0] request_say_va,
  input  logic             request_say__RDY,
  output logic             done__ENA,
  output logic [CNT_W-1:0] done_issued,
  output logic [CNT_W-1:0] done_stalls,
  input  logic             done__RDY,
  output logic [1:0]       dbg_state_o
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAPW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] va_q, va_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] stalls_q, stalls_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic fire;
  logic last_call;
  logic in_run;

  assign fire      = (state_q == S_ISSUE) && request_say__RDY;
  assign last_call = (remaining_q == CNT_W'(1));
  assign in_run    = (state_q == S_ISSUE) || (state_q == S_GAPW);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start__ENA) begin
          state_d = (start_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          if (last_call) begin
            state_d = S_DONE;
          end else if (GAP == 0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_GAPW;
          end
        end
      end
      S_GAPW: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        if (done__RDY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every other transition while a run is active.
    if (abort__ENA && in_run) begin
      state_d = S_DONE;
    end
  end

  // Output logic
  always_comb begin
    start__RDY       = (state_q == S_IDLE);
    abort__RDY       = in_run;
    request_say__ENA = fire;
    request_say_va   = va_q;
    done__ENA        = (state_q == S_DONE);
    done_issued      = issued_q;
    done_stalls      = stalls_q;
    dbg_state_o      = state_q;
  end

  // Datapath next-state. A fire in the abort cycle still advances va and
  // issued, because the call did complete.
  always_comb begin
    va_d        = va_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    issued_d    = issued_q;
    stalls_d    = stalls_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start__ENA) begin
          va_d        = start_base;
          step_d      = start_step;
          remaining_d = start_count;
          issued_d    = '0;
          stalls_d    = '0;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          va_d        = va_q + step_q;
          remaining_d = remaining_q - CNT_W'(1);
          issued_d    = issued_q + CNT_W'(1);
          gap_cnt_d   = GAP_LOAD;
        end else if (stalls_q != STALL_MAX) begin
          stalls_d = stalls_q + CNT_W'(1);
        end
      end
      S_GAPW: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      va_q        <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      stalls_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      va_q        <= va_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      stalls_q    <= stalls_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_order_say_source.sv
// tb_order_say_source
//   Drives two instances side by side: dut0 (GAP=0, 16-bit counters) and
//   dut1 (GAP=1, 4-bit counters so stall saturation is reachable). Every
//   cycle both are compared against a behavioural model of the run; say
//   values are checked against a queue of base + i*step.
module tb_order_say_source;

  logic clk;
  logic rst_n;

  logic        start_ena [2];
  logic [31:0] base_s    [2];
  logic [31:0] step_s    [2];
  logic [15:0] count0;
  logic [3:0]  count1;
  logic        abort_ena [2];
  logic        say_rdy   [2];
  logic        done_rdy  [2];

  logic        start_rdy [2];
  logic        abort_rdy [2];
  logic        say_ena   [2];
  logic [31:0] va        [2];
  logic        done_ena  [2];
  logic [15:0] issued0, stalls0;
  logic [3:0]  issued1, stalls1;
  logic [1:0]  dbg0, dbg1;

  int tests_run = 0;
  int fails     = 0;

  // Behavioural model
  bit          m_run   [2];
  bit          m_done  [2];
  int          m_gap   [2];
  int          m_k     [2];
  int          m_total [2];
  int          m_stalls[2];
  logic [31:0] m_base  [2];
  logic [31:0] m_step  [2];
  int          gapv    [2] = '{0, 1};
  int          smax    [2] = '{65535, 15};
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  order_say_source #(.WIDTH(32), .CNT_W(16), .GAP(0)) dut0 (
    .CLK(clk), .nRST(rst_n),
    .start__ENA(start_ena[0]), .start_base(base_s[0]), .start_step(step_s[0]),
    .start_count(count0), .start__RDY(start_rdy[0]),
    .abort__ENA(abort_ena[0]), .abort__RDY(abort_rdy[0]),
    .request_say__ENA(say_ena[0]), .request_say_va(va[0]),
    .request_say__RDY(say_rdy[0]),
    .done__ENA(done_ena[0]), .done_issued(issued0), .done_stalls(stalls0),
    .done__RDY(done_rdy[0]), .dbg_state_o(dbg0)
  );

  order_say_source #(.WIDTH(32), .CNT_W(4), .GAP(1)) dut1 (
    .CLK(clk), .nRST(rst_n),
    .start__ENA(start_ena[1]), .start_base(base_s[1]), .start_step(step_s[1]),
    .start_count(count1), .start__RDY(start_rdy[1]),
    .abort__ENA(abort_ena[1]), .abort__RDY(abort_rdy[1]),
    .request_say__ENA(say_ena[1]), .request_say_va(va[1]),
    .request_say__RDY(say_rdy[1]),
    .done__ENA(done_ena[1]), .done_issued(issued1), .done_stalls(stalls1),
    .done__RDY(done_rdy[1]), .dbg_state_o(dbg1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_issued(input int d);
    return (d == 0) ? 32'(issued0) : 32'(issued1);
  endfunction

  function automatic logic [31:0] obs_stalls(input int d);
    return (d == 0) ? 32'(stalls0) : 32'(stalls1);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] q_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_flush(input int d);
    if (d == 0) exp_q0.delete();
    else exp_q1.delete();
  endfunction

  function automatic void q_push(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endfunction

  function automatic void model_reset(input int d);
    m_run[d] = 0; m_done[d] = 0; m_gap[d] = 0; m_k[d] = 0;
    m_total[d] = 0; m_stalls[d] = 0; m_base[d] = '0; m_step[d] = '0;
    q_flush(d);
  endfunction

  // One clock of the model, using the inputs present at the rising edge.
  function automatic void model_adv(input int d);
    bit fire;
    if (!rst_n) begin
      model_reset(d);
      return;
    end
    if (!m_run[d] && !m_done[d]) begin
      if (start_ena[d]) begin
        m_base[d]   = base_s[d];
        m_step[d]   = step_s[d];
        m_k[d]      = 0;
        m_stalls[d] = 0;
        m_total[d]  = (d == 0) ? int'(count0) : int'(count1);
        q_flush(d);
        for (int i = 0; i < m_total[d]; i++) q_push(d, base_s[d] + 32'(i) * step_s[d]);
        if (m_total[d] == 0) m_done[d] = 1;
        else begin m_run[d] = 1; m_gap[d] = 0; end
      end
    end else if (m_done[d]) begin
      if (done_rdy[d]) m_done[d] = 0;
    end else begin
      fire = (m_gap[d] == 0) && say_rdy[d];
      if (m_gap[d] == 0 && !say_rdy[d] && m_stalls[d] < smax[d]) m_stalls[d]++;
      if (fire) m_k[d]++;
      if (abort_ena[d]) begin
        m_run[d] = 0; m_done[d] = 1; q_flush(d);
      end else if (fire) begin
        if (m_k[d] == m_total[d]) begin m_run[d] = 0; m_done[d] = 1; end
        else m_gap[d] = gapv[d];
      end else if (m_gap[d] > 0) begin
        m_gap[d]--;
      end
    end
  endfunction

  task automatic check_outputs(input int d);
    bit idle;
    idle = !m_run[d] && !m_done[d];
    check("start_rdy", d, 32'(start_rdy[d]), 32'(idle));
    check("abort_rdy", d, 32'(abort_rdy[d]), 32'(m_run[d]));
    check("say_ena", d, 32'(say_ena[d]),
          32'(m_run[d] && m_gap[d] == 0 && say_rdy[d]));
    check("done_ena", d, 32'(done_ena[d]), 32'(m_done[d]));
    check("done_issued", d, obs_issued(d), 32'(m_k[d]));
    check("done_stalls", d, obs_stalls(d), 32'(m_stalls[d]));
    if (say_ena[d] === 1'b1) begin
      if (q_size(d) == 0) check("fire_unexpected", d, 32'(say_ena[d]), 32'd0);
      else check("say_va", d, va[d], q_pop(d));
    end
  endtask

  // Sample at the falling edge, advance the model at the rising edge, then
  // return 1 time unit after the edge where inputs are driven.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_adv(d);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      start_ena[d] = 0; base_s[d] = '0; step_s[d] = '0;
      abort_ena[d] = 0; say_rdy[d] = 0; done_rdy[d] = 0;
    end
    count0 = '0; count1 = '0;
  endtask

  task automatic start_run(input int d, input logic [31:0] b, input logic [31:0] s,
                           input int cnt);
    base_s[d] = b; step_s[d] = s;
    if (d == 0) count0 = 16'(cnt); else count1 = 4'(cnt);
    start_ena[d] = 1;
    step();
    start_ena[d] = 0;
  endtask

  task automatic wait_done(input int d, input int ei, input int es, input bit use_exp,
                           input int hold);
    int n = 0;
    while (done_ena[d] !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("done_timeout", d, 32'(done_ena[d]), 32'd1);
    if (use_exp) begin
      check("run_issued", d, obs_issued(d), 32'(ei));
      check("run_stalls", d, obs_stalls(d), 32'(es));
    end
    repeat (hold) step();
    done_rdy[d] = 1;
    step();
    done_rdy[d] = 0;
  endtask

  initial begin
    int d, cnt, n;
    rst_n = 1'b0;
    idle_inputs();
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_start_rdy", k, 32'(start_rdy[k]), 32'd1);
      check("rst_say_ena", k, 32'(say_ena[k]), 32'd0);
      check("rst_done_ena", k, 32'(done_ena[k]), 32'd0);
      check("rst_abort_rdy", k, 32'(abort_rdy[k]), 32'd0);
      check("rst_va", k, va[k], 32'd0);
    end
    step();
    rst_n = 1'b1;
    step();

    // T1: GAP=0 back-to-back run
    say_rdy[0] = 1;
    start_run(0, 32'd10, 32'd3, 4);
    wait_done(0, 4, 0, 1, 0);

    // T2: GAP=1, five stalled ISSUE cycles before the second call
    say_rdy[1] = 1;
    start_run(1, 32'd10, 32'd3, 4);
    step();
    say_rdy[1] = 0;
    repeat (6) step();
    say_rdy[1] = 1;
    wait_done(1, 4, 5, 1, 0);

    // T3: count=0 goes straight to done
    start_run(0, 32'd5, 32'd5, 0);
    check("t3_done_next", 0, 32'(done_ena[0]), 32'd1);
    wait_done(0, 0, 0, 1, 0);

    // T4: va wraps modulo 2^32
    start_run(0, 32'hFFFF_FFFE, 32'd1, 3);
    wait_done(0, 3, 0, 1, 0);
    check("t4_va_after", 0, va[0], 32'h0000_0001);

    // T5a: abort while in the gap after two calls
    start_run(1, 32'd100, 32'd2, 6);
    repeat (3) step();
    abort_ena[1] = 1;
    step();
    abort_ena[1] = 0;
    wait_done(1, 2, 0, 1, 0);

    // T5b: abort in the same cycle as the third call
    start_run(1, 32'd100, 32'd2, 6);
    repeat (4) step();
    abort_ena[1] = 1;
    step();
    abort_ena[1] = 0;
    wait_done(1, 3, 0, 1, 0);

    // T6: reset in the middle of a run
    start_run(0, 32'd50, 32'd1, 8);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_say_ena_async", 0, 32'(say_ena[0]), 32'd0);
    check("t6_start_rdy_async", 0, 32'(start_rdy[0]), 32'd1);
    check("t6_done_async", 0, 32'(done_ena[0]), 32'd0);
    model_reset(0);
    model_reset(1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    start_run(0, 32'd100, 32'd7, 3);
    wait_done(0, 3, 0, 1, 0);

    // T7: done held for three cycles while the consumer is not ready
    start_run(1, 32'd1, 32'd1, 2);
    wait_done(1, 2, 0, 1, 3);

    // Stall counter saturates at 2^CNT_W-1 on the 4-bit instance
    say_rdy[1] = 0;
    start_run(1, 32'd9, 32'd9, 1);
    repeat (20) step();
    say_rdy[1] = 1;
    wait_done(1, 1, 15, 1, 0);

    // Randomized runs on either instance
    for (int it = 0; it < 24; it++) begin
      d   = int'($urandom_range(0, 1));
      cnt = int'($urandom_range(0, 8));
      say_rdy[d] = 1'($urandom_range(0, 1));
      start_run(d, $urandom, $urandom, cnt);
      n = 0;
      while (done_ena[d] !== 1'b1 && n < 300) begin
        say_rdy[d]   = ($urandom_range(0, 9) < 7);
        abort_ena[d] = m_run[d] && ($urandom_range(0, 39) == 0);
        step();
        abort_ena[d] = 0;
        n++;
      end
      wait_done(d, 0, 0, 0, int'($urandom_range(0, 2)));
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
